// File: rtl/hamming_top_level.sv
// 32-bit SECDED loopback: encode, optional single-bit injection at position 3,
// then decode/correct. Two register stages: codeword, then decoded result.
module hamming_top_level (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data,
    input  logic        inject_error,
    output logic [31:0] dec_data,
    output logic        single_err,
    output logic        double_err
);

    localparam int CW = 39;

    // Data bits fill every non-power-of-two position from 3 upward, in order.
    function automatic logic [CW-1:0] encode(input logic [31:0] d);
        logic [CW-1:0] c;
        logic [5:0]    par;
        int            j;
        c   = '0;
        par = '0;
        j   = 0;
        for (int p = 3; p < CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p[5:0]] = d[j[4:0]];
                j++;
            end
        end
        for (int p = 1; p < CW; p++)
            for (int k = 0; k < 6; k++)
                if (p[k]) par[k] ^= c[p[5:0]];
        for (int k = 0; k < 6; k++)
            c[6'(1 << k)] = par[k];
        c[0] = ^c[CW-1:1];
        return c;
    endfunction

    function automatic logic [31:0] extract(input logic [CW-1:0] c);
        logic [31:0] d;
        int          j;
        d = '0;
        j = 0;
        for (int p = 3; p < CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[j[4:0]] = c[p[5:0]];
                j++;
            end
        end
        return d;
    endfunction

    logic [CW-1:0] cw;
    logic [5:0]    syn;
    logic          pe;
    logic [CW-1:0] flip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cw <= '0;
        else        cw <= encode(data) ^ {35'b0, inject_error, 3'b0};
    end

    always_comb begin
        syn = '0;
        for (int p = 1; p < CW; p++)
            for (int k = 0; k < 6; k++)
                if (p[k]) syn[k] ^= cw[p[5:0]];
        pe   = ^cw;
        // syn=0 flips p0, which carries no data, so the p0-only case needs no special path.
        flip = {{(CW-1){1'b0}}, 1'b1} << syn;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_data   <= '0;
            single_err <= 1'b0;
            double_err <= 1'b0;
        end else if (pe && syn <= 6'd38) begin
            dec_data   <= extract(cw ^ flip);
            single_err <= 1'b1;
            double_err <= 1'b0;
        end else if (!pe && syn == 6'd0) begin
            dec_data   <= extract(cw);
            single_err <= 1'b0;
            double_err <= 1'b0;
        end else begin
            dec_data   <= extract(cw);
            single_err <= 1'b0;
            double_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hamming_top_level.sv
// Directed bench for the SECDED loopback: reset, clean/injected paths, streaming,
// forced-codeword decoder corners and mid-stream reset.
module tb_hamming_top_level;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data;
    logic        inject_error;
    logic [31:0] dec_data;
    logic        single_err;
    logic        double_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] pd;
    logic        pi;
    logic [38:0] fcw;

    hamming_top_level dut (
        .clk(clk), .rst_n(rst_n), .data(data), .inject_error(inject_error),
        .dec_data(dec_data), .single_err(single_err), .double_err(double_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one word, clock it, and check the word applied one step earlier.
    task automatic step(input logic [31:0] d, input logic inj, input string tag);
        data = d;
        inject_error = inj;
        tick();
        chk({tag, ".data"}, dec_data, pd);
        chk({tag, ".single"}, {31'b0, single_err}, {31'b0, pi});
        chk({tag, ".double"}, {31'b0, double_err}, 32'd0);
        pd = d;
        pi = inj;
    endtask

    // Reference encoder: parity p is the XOR over all positions sharing a bit with p.
    function automatic logic [38:0] ref_enc(input logic [31:0] d);
        logic [38:0] c;
        logic [38:0] m;
        int          j;
        c = '0;
        j = 0;
        for (int p = 1; p < 39; p++)
            if ($countones(p) != 1) begin
                c[p] = d[j];
                j++;
            end
        for (int b = 0; b < 6; b++) begin
            m = '0;
            for (int p = 1; p < 39; p++)
                if ((p & (1 << b)) != 0) m[p] = 1'b1;
            c[1 << b] = ^(c & m);
        end
        c[0] = ^c;
        return c;
    endfunction

    initial begin
        rst_n = 1'b0;
        data = 32'hFFFF_FFFF;
        inject_error = 1'b0;
        pd = 32'd0;
        pi = 1'b0;
        tick();
        tick();
        chk("rst.data", dec_data, 32'd0);
        chk("rst.single", {31'b0, single_err}, 32'd0);
        chk("rst.double", {31'b0, double_err}, 32'd0);

        rst_n = 1'b1;
        step(32'hFFFF_FFFF, 1'b0, "rel0");
        step(32'd12, 1'b0, "rel1");
        step(32'd12, 1'b1, "clean");
        step(32'd12, 1'b1, "inj");

        for (int i = 0; i < 8; i++)
            step(32'd8456, i[0], $sformatf("tog%0d", i));

        step(32'd0, 1'($urandom_range(0, 1)), "st0");
        step(32'd1, 1'($urandom_range(0, 1)), "st1");
        step(32'h8000_0000, 1'($urandom_range(0, 1)), "st2");
        step(32'hA5A5_5A5A, 1'($urandom_range(0, 1)), "st3");
        step(32'hFFFF_FFFF, 1'($urandom_range(0, 1)), "st4");
        step(32'hA5A5_5A5A, 1'b0, "st5");
        step(32'hA5A5_5A5A, 1'b0, "st6");

        for (int p = 0; p < 39; p++) begin
            fcw = ref_enc(32'hA5A5_5A5A) ^ (39'd1 << p);
            force dut.cw = fcw;
            tick();
            chk($sformatf("flip%0d.data", p), dec_data, 32'hA5A5_5A5A);
            chk($sformatf("flip%0d.single", p), {31'b0, single_err}, 32'd1);
            chk($sformatf("flip%0d.double", p), {31'b0, double_err}, 32'd0);
            release dut.cw;
        end
        fcw = ref_enc(32'hA5A5_5A5A) ^ 39'h28;
        force dut.cw = fcw;
        tick();
        chk("dbl.data", dec_data, 32'hA5A5_5A59);
        chk("dbl.single", {31'b0, single_err}, 32'd0);
        chk("dbl.double", {31'b0, double_err}, 32'd1);
        release dut.cw;
        tick();

        pd = 32'hA5A5_5A5A;
        pi = 1'b0;
        step(32'h1234_5678, 1'b1, "pre0");
        step(32'h0BAD_F00D, 1'b1, "pre1");
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.data", dec_data, 32'd0);
        chk("mid.single", {31'b0, single_err}, 32'd0);
        chk("mid.double", {31'b0, double_err}, 32'd0);
        tick();
        rst_n = 1'b1;
        pd = 32'd0;
        pi = 1'b0;
        step(32'hCAFE_0001, 1'b0, "post0");
        step(32'hCAFE_0002, 1'b0, "post1");
        step(32'hCAFE_0002, 1'b0, "post2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hamming_top_level.md
# hamming_top_level

Loopback block for the 32-bit Hamming SECDED datapath: it encodes a 32-bit data word into a 39-bit codeword and optionally flips one codeword bit to emulate a channel fault. It then decodes and corrects the word back to 32 bits. It is the integration wrapper used to exercise the encoder/decoder pair end to end. Error injection is a test hook, and the decoded output must equal the input data whenever at most one bit is in error.

## Interface
- No parameters; data width fixed at 32, codeword width fixed at 39.
- clk  input  1  single system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- data  input  32  data word to encode.
- inject_error  input  1  when 1, flip codeword position 3 (carries data[0]) before decoding.
- dec_data  output  32  decoded, corrected data word.
- single_err  output  1  decoder found and corrected a single-bit error.
- double_err  output  1  decoder detected an uncorrectable error; dec_data is uncorrected.

## Operation
- **Codeword layout:**
  - Positions 0..38.
  - Position 0 is overall parity p0.
  - Positions 1, 2, 4, 8, 16 and 32 are Hamming parity bits.
  - Remaining positions 3, 5, 6, 7, 9..15, 17..31 and 33..38 hold data[0]..data[31] in ascending order. For example, data[0]→3, data[4]→9, data[11]→17, data[26]→33, data[31]→38.
- **Encode:**
  - Parity at position 2^k is the XOR of all data-carrying positions whose index has bit k set (k=0..5).
  - p0 is the XOR of positions 1..38, giving even parity over all 39 bits.
- **Inject:** the codeword is XORed with a mask that has only bit 3 set when inject_error=1, and is all-zero otherwise.
- **Decode:**
  - Syndrome s[5:0]: bit k is the XOR of every position 1..38 whose index has bit k set, including the parity bit itself.
  - Overall check pe is the XOR of all 39 bits.
- **Classification:**
  - s=0, pe=0: no error. Data passed through; single_err=0, double_err=0.
  - s≠0, pe=1, s≤38: flip position s, then extract data; single_err=1.
  - s=0, pe=1: error in p0 only. Data is unaffected; single_err=1.
  - s≠0, pe=0: double error. Data extracted uncorrected; double_err=1.
  - s>38, pe=1: not a legal single error; treated as double_err=1, data uncorrected.
- single_err and double_err are never both 1.

## Timing
- Two-stage pipeline:
  - Edge N: the codeword register captures encode(data) XOR the inject mask, with data and inject_error sampled at that same edge.
  - Edge N+1: dec_data, single_err and double_err capture the decode of that registered codeword.
- Latency is 2 clocks from input sample to output.
- Throughput is one word per clock. No handshake; every cycle is valid.
- Reset (rst_n=0, asynchronous):
  - The codeword register clears to all-zero, which is the valid codeword of data 0.
  - dec_data=0, single_err=0, double_err=0, held while rst_n is low.
  - The first valid output appears 2 rising edges after rst_n deasserts.
- Reset asserted mid-stream immediately discards both pipeline stages; no partial output is produced.
- Changing inject_error alone, with data held, affects only the flags 2 cycles later; dec_data is unchanged.

## Test plan
- **Reset:** hold rst_n=0 with data=32'hFFFF_FFFF → dec_data=0, both flags 0. Release reset → dec_data=32'hFFFF_FFFF after 2 edges.
- **Clean path:** data=32'd12, inject_error=0 → dec_data=32'd12 after 2 clocks, single_err=0, double_err=0.
- **Injected error:** data=32'd12, inject_error=1 → dec_data=32'd12, single_err=1, double_err=0. Repeat with data=32'd8456, toggling inject_error every cycle → dec_data stays 8456 and single_err follows inject_error delayed 2 cycles.
- **Streaming:** consecutive words 0, 1, 32'h8000_0000, 32'hA5A5_5A5A and 32'hFFFF_FFFF, one per clock with random inject_error → each appears unchanged exactly 2 clocks later, and single_err matches the injection history.
- **Decoder corner cases** (force the internal codeword register):
  - Single flip at each of positions 0..38 → data corrected, single_err=1.
  - Two flips at positions 3 and 5 → double_err=1, single_err=0.
- **Reset mid-stream:** assert rst_n low between two valid words → outputs go to 0 asynchronously, without waiting for a clock edge. After release, no stale word is emitted.
